// File: rtl/counter_monitor_if.sv
// Bundle between an up/down counter's control/observe side and its monitor.
// Ports: enable, direction, counter_in, clr in; mismatch, err, expected, state, err_count out.
interface counter_monitor_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             direction;
  logic [WIDTH-1:0] counter_in;
  logic             clr;
  logic             mismatch;
  logic             err;
  logic [WIDTH-1:0] expected;
  logic [1:0]       state;
  logic [7:0]       err_count;

  modport master (
    output enable,
    output direction,
    output counter_in,
    output clr,
    input  mismatch,
    input  err,
    input  expected,
    input  state,
    input  err_count
  );

  modport slave (
    input  enable,
    input  direction,
    input  counter_in,
    input  clr,
    output mismatch,
    output err,
    output expected,
    output state,
    output err_count
  );
endinterface

// File: rtl/counter_monitor.sv
// On-line checker: predicts each next counter sample and flags deviations.
// Ports: clk, rst (async high), bus (slave). Macro COUNTER_MONITOR_ERR_COUNT_EN builds err_count.
module counter_monitor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  counter_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    TRACK = 2'b01,
    FAULT = 2'b10
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] pred;
  logic [WIDTH-1:0] ref_val;
  logic             en_q;
  logic             dir_q;
  logic             miss;
  logic             mismatch_q;
  logic             err_q;

  // Modulo 2^WIDTH arithmetic: wraps in both directions are legal.
  always_comb begin
    pred = prev;
    if (en_q) begin
      if (dir_q) pred = prev + WIDTH'(1);
      else       pred = prev - WIDTH'(1);
    end
  end

  // The counter shares our reset, so its first value must be zero.
  assign ref_val = (state_q == SYNC) ? '0 : pred;
  assign miss    = (bus.counter_in != ref_val);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:    state_d = miss ? FAULT : TRACK;
      TRACK:   state_d = miss ? FAULT : TRACK;
      FAULT:   state_d = FAULT;
      default: state_d = SYNC;
    endcase
    // clr discards this cycle's verdict; SYNC stays SYNC.
    if (bus.clr) begin
      state_d = (state_q == SYNC) ? SYNC : TRACK;
    end
  end

  // Re-base on every observed value so one bad step counts once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      en_q  <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      prev  <= bus.counter_in;
      en_q  <= bus.enable;
      dir_q <= bus.direction;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (bus.clr) begin
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mismatch_q <= miss;
      err_q      <= err_q | miss;
    end
  end

`ifdef COUNTER_MONITOR_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (bus.clr) begin
      err_cnt_q <= 8'd0;
    end else if (miss && err_cnt_q != 8'hff) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_count = err_cnt_q;
`else
  assign bus.err_count = 8'd0;
`endif

  assign bus.mismatch = mismatch_q;
  assign bus.err      = err_q;
  assign bus.expected = ref_val;
  assign bus.state    = state_q;

endmodule
